// File: rtl/soc_vector_sampler.sv
// Windowed, periodic multi-channel pad sampler that time-stamps each sample
// and queues it in a FIFO behind a valid/ready port. It also provides change-only compression and drop accounting.
module soc_vector_sampler #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned TIME_W     = 32,
  parameter int unsigned PERIOD_W   = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [TIME_W-1:0]   sample_start,
  input  logic [TIME_W-1:0]   sample_stop,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic                change_only,
  input  logic [CH_NUM-1:0]   pad_in,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic [TIME_W-1:0]   vec_time,
  output logic [CH_NUM-1:0]   vec_data,
  output logic                sampling,
  output logic                done,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt,
  input  logic                ovf_clr
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = TIME_W + CH_NUM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                en_q;
  logic [TIME_W-1:0]   t_q, t_d;
  logic [TIME_W-1:0]   start_q, start_d;
  logic [TIME_W-1:0]   stop_q, stop_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] period_m1;
  logic                chg_q, chg_d;
  logic [CH_NUM-1:0]   sync1_q, sync1_d;
  logic [CH_NUM-1:0]   sync_pad_q, sync_pad_d;
  logic [CH_NUM-1:0]   last_q, last_d;
  logic                have_last_q, have_last_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       head;
  logic                ovf_q, ovf_d;
  logic [DROP_W-1:0]   drop_q, drop_d, drop_base;

  logic run_edge;
  logic t_sat;
  logic sample_pt;
  logic want;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    run_edge = (state_q == ST_IDLE) && en && !en_q;
    t_sat    = (t_q == '1);
  end

  // Next-state logic; start==0 skips WAIT so the first sample lands at t=0
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_edge) begin
          if ((sample_start == '0) && (sample_stop != '0)) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (t_sat || (stop_q <= start_q)) begin
          state_d = ST_DONE;
        end else if ((t_q + TIME_W'(1)) == start_q) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (t_sat || (t_q == (stop_q - TIME_W'(1)))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
    endcase
    if (!en) begin
      state_d = ST_IDLE;
    end
  end

  // State-decoded outputs
  always_comb begin
    sampling = (state_q == ST_SAMPLE);
    done     = (state_q == ST_DONE);
  end

  // Run configuration, time and phase counters
  always_comb begin
    start_d  = run_edge ? sample_start  : start_q;
    stop_d   = run_edge ? sample_stop   : stop_q;
    period_d = run_edge ? sample_period : period_q;
    chg_d    = run_edge ? change_only   : chg_q;

    period_m1 = (period_q == '0) ? '0 : (period_q - PERIOD_W'(1));

    t_d = t_q;
    unique case (state_q)
      ST_IDLE:             t_d = '0;
      ST_WAIT, ST_SAMPLE:  t_d = t_sat ? t_q : (t_q + TIME_W'(1));
      ST_DONE:             t_d = t_q;
    endcase
    if (!en) begin
      t_d = '0;
    end

    sample_pt = 1'b0;
    phase_d   = '0;
    if (state_q == ST_SAMPLE) begin
      if (phase_q == '0) begin
        sample_pt = 1'b1;
        phase_d   = period_m1;
      end else begin
        phase_d = phase_q - PERIOD_W'(1);
      end
    end
  end

  // Synchronizer, change-only compare, FIFO pointers and drop accounting
  always_comb begin
    sync1_d    = pad_in;
    sync_pad_d = sync1_q;

    count = wr_ptr_q - rd_ptr_q;
    full  = (count == (AW + 1)'(FIFO_DEPTH));
    pop   = vec_valid && vec_ready;

    want = sample_pt && (!chg_q || !have_last_q || (sync_pad_q != last_q));
    push = want && (!full || pop);
    drop = want && full && !pop;

    wr_ptr_d = push ? (wr_ptr_q + (AW + 1)'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + (AW + 1)'(1)) : rd_ptr_q;

    last_d      = push ? sync_pad_q : last_q;
    have_last_d = have_last_q;
    if (run_edge) begin
      have_last_d = 1'b0;
    end else if (push) begin
      have_last_d = 1'b1;
    end

    // Clear is applied first so a coincident drop leaves a count of one
    drop_base = ovf_clr ? '0 : drop_q;
    ovf_d     = ovf_clr ? 1'b0 : ovf_q;
    drop_d    = drop_base;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_base == '1) ? drop_base : (drop_base + DROP_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q        <= 1'b0;
      t_q         <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      period_q    <= '0;
      phase_q     <= '0;
      chg_q       <= 1'b0;
      sync1_q     <= '0;
      sync_pad_q  <= '0;
      last_q      <= '0;
      have_last_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      en_q        <= en;
      t_q         <= t_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      period_q    <= period_d;
      phase_q     <= phase_d;
      chg_q       <= chg_d;
      sync1_q     <= sync1_d;
      sync_pad_q  <= sync_pad_d;
      last_q      <= last_d;
      have_last_q <= have_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {t_q, sync_pad_q};
    end
  end

  always_comb begin
    head      = mem_q[rd_ptr_q[AW-1:0]];
    vec_valid = (count != '0);
    vec_time  = vec_valid ? head[EW-1:CH_NUM] : '0;
    vec_data  = vec_valid ? head[CH_NUM-1:0]  : '0;
    overflow  = ovf_q;
    drop_cnt  = drop_q;
  end

endmodule

// File: tb/tb_soc_vector_sampler.sv
// Directed bench for soc_vector_sampler: a queue-based behavioural model is
// checked every cycle, and hand-computed literals pin the popped entry streams.
module tb_soc_vector_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [31:0] sample_start = '0;
  logic [31:0] sample_stop = '0;
  logic [15:0] sample_period = '0;
  logic        change_only = 1'b0;
  logic [3:0]  pad_in = '0;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  logic [31:0] vec_time;
  logic [3:0]  vec_data;
  logic        sampling;
  logic        done;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  soc_vector_sampler #(
    .CH_NUM(4), .TIME_W(32), .PERIOD_W(16), .FIFO_DEPTH(16), .DROP_W(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .sample_start(sample_start), .sample_stop(sample_stop),
    .sample_period(sample_period), .change_only(change_only),
    .pad_in(pad_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_time(vec_time), .vec_data(vec_data), .sampling(sampling),
    .done(done), .overflow(overflow), .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Behavioural model: runs are described by "cycles since the enable edge"
  typedef struct {
    longint t;
    int     d;
  } ent_t;

  ent_t   mq[$];
  bit     m_run, m_prev_en, m_chg, m_have_last, m_ovf;
  longint m_t, m_start, m_stop, m_per;
  int     m_last, m_drop, h1, h2;

  function automatic bit model_sampling();
    return m_run && (m_start < m_stop) && (m_t >= m_start) && (m_t < m_stop);
  endfunction

  function automatic bit model_done();
    if (!m_run) return 1'b0;
    if (m_stop <= m_start) return m_t >= 1;
    return m_t >= m_stop;
  endfunction

  always @(posedge clk) begin
    int     sd;
    bit     pop, full, samp, want;
    longint per_eff;
    ent_t   e;
    if (!reset) begin
      mq.delete();
      m_run = 0; m_prev_en = 0; m_chg = 0; m_have_last = 0; m_ovf = 0;
      m_t = 0; m_start = 0; m_stop = 0; m_per = 0;
      m_last = 0; m_drop = 0; h1 = 0; h2 = 0;
    end else begin
      sd      = h2;
      per_eff = (m_per == 0) ? 1 : m_per;
      full    = (mq.size() == 16);
      pop     = (mq.size() > 0) && vec_ready;
      samp    = model_sampling() && (((m_t - m_start) % per_eff) == 0);
      want    = samp && (!m_chg || !m_have_last || (sd != m_last));
      if (ovf_clr) begin
        m_ovf = 0;
        m_drop = 0;
      end
      if (pop) void'(mq.pop_front());
      if (want) begin
        if (!full || pop) begin
          e.t = m_t;
          e.d = sd;
          mq.push_back(e);
          m_last = sd;
          m_have_last = 1;
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      if (!en) begin
        m_run = 0;
      end else if (m_run) begin
        m_t++;
      end else if (!m_prev_en) begin
        m_run = 1;
        m_t = 0;
        m_start = sample_start;
        m_stop = sample_stop;
        m_per = sample_period;
        m_chg = change_only;
        m_have_last = 0;
      end
      m_prev_en = en;
      h2 = h1;
      h1 = pad_in;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Entries seen leaving the DUT, for literal checks of whole streams
  int log_t[$];
  int log_d[$];
  int exp_t[$];
  int exp_d[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("sampling", 64'(sampling), 64'(model_sampling()));
      check("done", 64'(done), 64'(model_done()));
      check("vec_valid", 64'(vec_valid), 64'(mq.size() > 0));
      check("vec_time", 64'(vec_time), (mq.size() > 0) ? 64'(mq[0].t) : 64'd0);
      check("vec_data", 64'(vec_data), (mq.size() > 0) ? 64'(mq[0].d) : 64'd0);
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      if (vec_valid && vec_ready) begin
        log_t.push_back(int'(vec_time));
        log_d.push_back(int'(vec_data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string nm);
    check({nm, "_count"}, 64'(log_t.size()), 64'(exp_t.size()));
    for (int i = 0; i < exp_t.size(); i++) begin
      check({nm, "_time"}, (i < log_t.size()) ? 64'(log_t[i]) : 64'hFFFF_FFFF, 64'(exp_t[i]));
      if (i < exp_d.size())
        check({nm, "_data"}, (i < log_d.size()) ? 64'(log_d[i]) : 64'hFFFF_FFFF, 64'(exp_d[i]));
    end
    log_t.delete();
    log_d.delete();
    exp_t.delete();
    exp_d.delete();
  endtask

  task automatic config_run(input int s, input int p, input int per, input bit c);
    sample_start  = 32'(s);
    sample_stop   = 32'(p);
    sample_period = 16'(per);
    change_only   = c;
  endtask

  initial begin
    tick(3);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(vec_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    tick(1);
    reset = 1'b1;
    tick(2);

    // Basic window
    config_run(10, 50, 8, 0);
    pad_in = 4'hA;
    vec_ready = 1'b1;
    en = 1'b1;
    tick(1);
    tick(55);
    @(negedge clk);
    check("basic_done", 64'(done), 64'd1);
    check("basic_sampling", 64'(sampling), 64'd0);
    en = 1'b0;
    tick(3);
    exp_t = {10, 18, 26, 34, 42};
    exp_d = {10, 10, 10, 10, 10};
    check_log("basic");

    // Period 0 with synchronizer latency
    pad_in = 4'h0;
    config_run(0, 4, 0, 0);
    tick(3);
    en = 1'b1;
    tick(1);
    pad_in = 4'h1;
    tick(10);
    en = 1'b0;
    tick(3);
    exp_t = {0, 1, 2, 3};
    exp_d = {0, 0, 1, 1};
    check_log("per0");

    // Change-only
    pad_in = 4'h3;
    config_run(10, 40, 1, 1);
    tick(3);
    en = 1'b1;
    tick(1);
    tick(20);
    pad_in = 4'h5;
    tick(30);
    en = 1'b0;
    tick(3);
    exp_t = {10, 22};
    exp_d = {3, 5};
    check_log("chg");

    // Overflow: 20 samples into 16 entries
    vec_ready = 1'b0;
    config_run(0, 20, 1, 0);
    en = 1'b1;
    tick(1);
    tick(20);
    @(negedge clk);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drops", 64'(drop_cnt), 64'd4);
    check("ovf_head", 64'(vec_time), 64'd0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clr_flag", 64'(overflow), 64'd0);
    check("clr_drops", 64'(drop_cnt), 64'd0);

    // Drop coincident with clear: the drop wins
    en = 1'b0;
    config_run(0, 1, 1, 0);
    tick(2);
    en = 1'b1;
    tick(1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check("clrdrop_flag", 64'(overflow), 64'd1);
    check("clrdrop_drops", 64'(drop_cnt), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;

    // Full FIFO with simultaneous pop; then drain old entries ahead of new
    en = 1'b0;
    config_run(0, 3, 1, 0);
    tick(2);
    log_t.delete();
    log_d.delete();
    en = 1'b1;
    tick(1);
    vec_ready = 1'b1;
    tick(3);
    vec_ready = 1'b0;
    @(negedge clk);
    check("fullpop_flag", 64'(overflow), 64'd0);
    check("fullpop_drops", 64'(drop_cnt), 64'd0);
    check("fullpop_head", 64'(vec_time), 64'd3);
    vec_ready = 1'b1;
    en = 1'b0;
    tick(20);
    exp_t = {0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2};
    check_log("fullpop");

    // Abort mid-SAMPLE, then drain
    vec_ready = 1'b0;
    config_run(5, 100, 4, 0);
    en = 1'b1;
    tick(1);
    tick(15);
    en = 1'b0;
    tick(1);
    @(negedge clk);
    check("abort_sampling", 64'(sampling), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_valid", 64'(vec_valid), 64'd1);
    vec_ready = 1'b1;
    tick(10);
    exp_t = {5, 9, 13};
    check_log("abort");

    // Degenerate window
    config_run(30, 20, 1, 0);
    en = 1'b1;
    tick(40);
    @(negedge clk);
    check("degen_done", 64'(done), 64'd1);
    check("degen_valid", 64'(vec_valid), 64'd0);
    en = 1'b0;
    tick(2);
    check_log("degen");

    // Reset mid-run
    vec_ready = 1'b0;
    config_run(2, 100, 1, 0);
    en = 1'b1;
    tick(10);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("rstrun_valid", 64'(vec_valid), 64'd0);
    check("rstrun_sampling", 64'(sampling), 64'd0);
    check("rstrun_time", 64'(vec_time), 64'd0);
    en = 1'b0;
    reset = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_vector_sampler.md
Name: soc_vector_sampler

Overview:
- Synthesizable multi-channel pad/vector sampler, parametrised successor to the bench-side hsim vector dump.
- Samples CH_NUM pad signals at a programmable period inside a programmable [start, stop) cycle window.
- Stamps each sample with a cycle-accurate time and buffers it in a FIFO behind a valid/ready port for an on-chip logger or the bench.
- Adds change-only compression, overflow detection with drop counting, and run-time programmable window and period.

Parameters:
- CH_NUM, 4: number of sampled channels (1..64).
- TIME_W, 32: width of the time counter and time stamps.
- PERIOD_W, 16: width of the sample-period register.
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥2.
- DROP_W, 8: width of the dropped-sample counter.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: reset, synchronous, active-low.
- en, input, 1: run enable; a 0→1 edge starts a run.
- sample_start, input, TIME_W: first sample time in cycles after the run starts.
- sample_stop, input, TIME_W: window end, exclusive.
- sample_period, input, PERIOD_W: cycles between samples; 0 is treated as 1.
- change_only, input, 1: 1 = push only samples whose data differs from the last pushed data.
- pad_in, input, CH_NUM: asynchronous pad signals.
- vec_valid, output, 1: FIFO head valid.
- vec_ready, input, 1: consumer accepts the head.
- vec_time, output, TIME_W: head time stamp.
- vec_data, output, CH_NUM: head sample data.
- sampling, output, 1: state is SAMPLE.
- done, output, 1: state is DONE.
- overflow, output, 1: sticky flag, set when a sample is dropped.
- drop_cnt, output, DROP_W: saturating count of dropped samples.
- ovf_clr, input, 1: clears overflow and drop_cnt.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - Time counter, phase counter, synchronizers, FIFO pointers and last-data register clear.
  - All outputs are 0.
- Synchronizer: pad_in passes through a 2-flop synchronizer, sync_pad. A pad change is visible in a sample taken ≥2 cycles later.
- Inputs sample_start, sample_stop, sample_period and change_only are latched on the en 0→1 edge and stay constant for the run.
- Time counter t:
  - Held at 0 in IDLE.
  - Increments by 1 per cycle in WAIT and SAMPLE.
  - Saturates at all-ones, which forces DONE.
- State machine, states IDLE, WAIT, SAMPLE, DONE:
  - IDLE→WAIT on the en rising edge; t=0 in the first WAIT cycle.
  - WAIT→SAMPLE when t==start. If start==0, SAMPLE is entered in the cycle after the edge.
  - WAIT→DONE directly if stop≤start; no samples are taken.
  - SAMPLE→DONE when t==stop-1 has been processed, so the last possible sample time is stop-1.
  - DONE holds until en=0.
  - en=0 in any state→IDLE next cycle and t clears. The FIFO contents are retained and remain drainable.
- Sample points:
  - First sample at t==start.
  - Then every max(period,1) cycles while t<stop, tracked by a phase counter that reloads at each sample point.
- Sample entry: {t, sync_pad} captured at the sample point.
- Change-only mode:
  - The first sample of a run is always pushed.
  - A later sample is pushed only if sync_pad ≠ last pushed data.
  - Suppressed samples are not counted as drops.
- FIFO:
  - Head is presented combinationally from storage; vec_valid = !empty.
  - Pop when vec_valid & vec_ready.
  - Push is visible at the head the cycle after the push, so sample-to-vec_valid latency is 1 cycle when the FIFO was empty.
  - Push when full with no pop: the sample is dropped, overflow←1, and drop_cnt increments, saturating at all-ones.
  - Push when full with a simultaneous pop: the push is accepted and nothing is dropped.
  - vec_time and vec_data are stable while vec_valid=1 and vec_ready=0.
- ovf_clr: clears overflow and drop_cnt. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- New run with a non-empty FIFO: old entries stay ahead of new ones; time stamps restart from 0.

Test Plan:
- Basic window:
  - Stimulus: start=10, stop=50, period=8, change_only=0, vec_ready=1.
  - Response: 5 entries with times 10,18,26,34,42; done=1 from cycle 50 on; sampling=1 only for t in 10..49.
- Period 0 and synchronizer latency:
  - Stimulus: start=0, stop=4, period=0; pad_in toggles from 0 to 1 at t=0.
  - Response: entries at times 0,1,2,3; data is 0 until 2 cycles after the toggle, then 1.
- Change-only mode:
  - Stimulus: period=1; pad_in=0x3 held, then 0x5 at t=20, window 10..40.
  - Response: exactly two entries: (10,0x3) and (22,0x5).
- Overflow:
  - Stimulus: FIFO_DEPTH=16, vec_ready=0, 20 samples; then ovf_clr pulse.
  - Response: 16 entries retained with the first 16 times; overflow=1; drop_cnt=4; after ovf_clr, overflow=0 and drop_cnt=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full, vec_ready=1 in the same cycle as a sample push.
  - Response: no drop; occupancy stays 16; order is preserved.
- Abort and degenerate window:
  - Stimulus: en dropped mid-SAMPLE; separately, stop≤start (start=30, stop=20).
  - Response: IDLE next cycle; t=0; the FIFO still drains correctly. With stop≤start, WAIT→DONE and no entries are pushed.
  - Also: reset asserted mid-run clears all outputs at the next clk edge.
